dual_port_ram_param: RTL and testbench



---
 rtl/dual_port_ram_param.sv | 225 ++++++++++++++++++++++
 tb/tb_dual_port_ram_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_param.sv
// ---------------------------------------------------------------------------
// dual_port_ram_param
//
// Parametrised true dual-port synchronous RAM shared by two independent bus
// masters (A and B) in a single clock domain.
//
// After reset is released an internal sequencer writes zero to every word,
// one word per cycle. While it runs, init_busy is high and port requests are
// ignored. Once the sweep is done, both ports may read or write every cycle.
//
// Optional feature macro: RAM_WRITE_FIRST_EN
//   undefined (default) : a read that hits a same-cycle write on the other
//                         port returns the old word (read-first).
//   defined             : such a read returns the merged new word
//                         (write-first forwarding).
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width
//   DEPTH   number of words, 1 .. 2**ADDR_W
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active low
//   en_a / en_b          port request enable
//   we_a / we_b          1 = write, 0 = read (qualified by en_x)
//   be_a / be_b          byte write enables, bit i covers data_x[8i+7:8i]
//   addr_a / addr_b      word address (>= DEPTH: write ignored, read gives 0)
//   data_a / data_b      write data
//   dataout_a/dataout_b  registered read data, held between reads
//   valid_a / valid_b    one-cycle pulse with each read result
//   init_busy            high while the zero-fill sweep runs
//   collision            one-cycle pulse after a same-address write/write
//                        with overlapping byte enables (A's bytes win)
// ---------------------------------------------------------------------------
module dual_port_ram_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     data_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     data_b,
  output logic [DATA_W-1:0]     dataout_a,
  output logic [DATA_W-1:0]     dataout_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   init_cnt_r, init_cnt_nxt_s;

  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                run_s;
  logic                in_range_a_s, in_range_b_s;
  logic                wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic                same_addr_s, coll_s;
  logic [DATA_W-1:0]   old_a_s, old_b_s;
  logic [DATA_W-1:0]   new_a_s, new_b_s;
  logic [DATA_W-1:0]   rdata_a_s, rdata_b_s;

  logic [DATA_W-1:0]   dataout_a_r, dataout_b_r;
  logic                valid_a_r, valid_b_r, collision_r;

  // Replace the byte lanes selected by be with the lanes of new_w.
  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Sequencer state and sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Sequencer next state: sweep 0..DEPTH-1, then stay in RUN until reset.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == LAST_ADDR) begin
          state_nxt_s    = ST_RUN;
          init_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s    = ST_INIT;
          init_cnt_nxt_s = init_cnt_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt_s    = ST_RUN;
        init_cnt_nxt_s = {ADDR_W{1'b0}};
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Request qualification, collision detect and read/write word formation.
  always_comb begin
    run_s        = (state_r == ST_RUN);
    in_range_a_s = ({1'b0, addr_a} < DEPTH_L);
    in_range_b_s = ({1'b0, addr_b} < DEPTH_L);
    wr_a_s       = run_s & en_a & we_a & in_range_a_s;
    wr_b_s       = run_s & en_b & we_b & in_range_b_s;
    rd_a_s       = run_s & en_a & ~we_a;
    rd_b_s       = run_s & en_b & ~we_b;
    same_addr_s  = (addr_a == addr_b);
    coll_s       = wr_a_s & wr_b_s & same_addr_s & (|(be_a & be_b));

    old_a_s = in_range_a_s ? mem_r[addr_a] : {DATA_W{1'b0}};
    old_b_s = in_range_b_s ? mem_r[addr_b] : {DATA_W{1'b0}};

    // B's word is built first; A's word starts from it on a shared address
    // so that B-only lanes survive and A wins overlapping lanes.
    new_b_s = merge_word(old_b_s, data_b, be_b);
    if (wr_b_s && same_addr_s) begin
      new_a_s = merge_word(new_b_s, data_a, be_a);
    end else begin
      new_a_s = merge_word(old_a_s, data_a, be_a);
    end

`ifdef RAM_WRITE_FIRST_EN
    // The reading port does not write, so the other port's new word is the
    // fully merged result.
    if (wr_b_s && same_addr_s) begin
      rdata_a_s = new_b_s;
    end else begin
      rdata_a_s = old_a_s;
    end
    if (wr_a_s && same_addr_s) begin
      rdata_b_s = new_a_s;
    end else begin
      rdata_b_s = old_b_s;
    end
`else
    rdata_a_s = old_a_s;
    rdata_b_s = old_b_s;
`endif
  end

  // Storage array: zero sweep in INIT, port writes in RUN (A's NBA last wins).
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_cnt_r] <= {DATA_W{1'b0}};
    end else begin
      if (wr_b_s) begin
        mem_r[addr_b] <= new_b_s;
      end
      if (wr_a_s) begin
        mem_r[addr_a] <= new_a_s;
      end
    end
  end

  // Read data registers, valid strobes and collision pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout_a_r <= {DATA_W{1'b0}};
      dataout_b_r <= {DATA_W{1'b0}};
      valid_a_r   <= 1'b0;
      valid_b_r   <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      if (rd_a_s) begin
        dataout_a_r <= rdata_a_s;
      end
      if (rd_b_s) begin
        dataout_b_r <= rdata_b_s;
      end
      valid_a_r   <= rd_a_s;
      valid_b_r   <= rd_b_s;
      collision_r <= coll_s;
    end
  end

  assign dataout_a = dataout_a_r;
  assign dataout_b = dataout_b_r;
  assign valid_a   = valid_a_r;
  assign valid_b   = valid_b_r;
  assign collision = collision_r;
  assign init_busy = (state_r == ST_INIT);

endmodule

// File: tb/tb_dual_port_ram_param.sv
module tb_dual_port_ram_param;

  logic        clk;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic [15:0] dataout_a, dataout_b;
  logic        valid_a, valid_b, init_busy, collision;

  // second instance with DEPTH smaller than the address space
  logic        rst2;
  logic        en_a2, we_a2, en_b2, we_b2;
  logic [1:0]  be_a2, be_b2;
  logic [7:0]  addr_a2, addr_b2;
  logic [15:0] data_a2, data_b2;
  logic [15:0] dataout_a2, dataout_b2;
  logic        valid_a2, valid_b2, init_busy2, collision2;

  int checks = 0;
  int failures = 0;

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
    .dataout_a(dataout_a), .dataout_b(dataout_b),
    .valid_a(valid_a), .valid_b(valid_b),
    .init_busy(init_busy), .collision(collision)
  );

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut2 (
    .clk(clk), .rst(rst2),
    .en_a(en_a2), .we_a(we_a2), .be_a(be_a2), .addr_a(addr_a2), .data_a(data_a2),
    .en_b(en_b2), .we_b(we_b2), .be_b(be_b2), .addr_b(addr_b2), .data_b(data_b2),
    .dataout_a(dataout_a2), .dataout_b(dataout_b2),
    .valid_a(valid_a2), .valid_b(valid_b2),
    .init_busy(init_busy2), .collision(collision2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_WRITE_FIRST_EN
  localparam logic [15:0] RW_EXP = 16'h00FF;
`else
  localparam logic [15:0] RW_EXP = 16'h0005;
`endif

  // ---------------- reference model (byte image of the RAM) ----------------
  logic [7:0]  ref_b [0:511];
  logic        m_va, m_vb, m_col;
  logic [15:0] m_da, m_db;

  function automatic logic [15:0] ref_word(input logic [7:0] a);
    return {ref_b[int'(a) * 2 + 1], ref_b[int'(a) * 2]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) ref_b[i] = 8'h00;
    m_va = 1'b0; m_vb = 1'b0; m_col = 1'b0;
    m_da = 16'h0000; m_db = 16'h0000;
  endtask

  task automatic model_step(
    input logic ea, wa, input logic [1:0] ba, input logic [7:0] aa, input logic [15:0] wda,
    input logic eb, wb, input logic [1:0] bb, input logic [7:0] ab, input logic [15:0] wdb);
    logic [15:0] pre_a, pre_b;
    pre_a = ref_word(aa);
    pre_b = ref_word(ab);
    // B lanes land first, A lanes on top: A owns every lane it enables
    for (int i = 0; i < 2; i++)
      if (eb && wb && bb[i]) ref_b[int'(ab) * 2 + i] = wdb[8*i +: 8];
    for (int i = 0; i < 2; i++)
      if (ea && wa && ba[i]) ref_b[int'(aa) * 2 + i] = wda[8*i +: 8];
    m_col = ea && wa && eb && wb && (aa == ab) && ((ba & bb) != 2'b00);
    m_va = ea && !wa;
    m_vb = eb && !wb;
`ifdef RAM_WRITE_FIRST_EN
    if (m_va) m_da = ref_word(aa);
    if (m_vb) m_db = ref_word(ab);
`else
    if (m_va) m_da = pre_a;
    if (m_vb) m_db = pre_b;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drive one request cycle on DUT1, update the model, sample #1 after edge
  task automatic apply(
    input logic ea, wa, input logic [1:0] ba, input logic [7:0] aa, input logic [15:0] wda,
    input logic eb, wb, input logic [1:0] bb, input logic [7:0] ab, input logic [15:0] wdb);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = wda;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = wdb;
    model_step(ea, wa, ba, aa, wda, eb, wb, bb, ab, wdb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = 8'd0; data_a = 16'h0000;
    en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = 8'd0; data_b = 16'h0000;
  endtask

  task automatic count_init1(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid_a"}, 32'(valid_a), 32'(m_va));
    chk({tag, " dataout_a"}, 32'(dataout_a), 32'(m_da));
    chk({tag, " valid_b"}, 32'(valid_b), 32'(m_vb));
    chk({tag, " dataout_b"}, 32'(dataout_b), 32'(m_db));
    chk({tag, " collision"}, 32'(collision), 32'(m_col));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        ea; logic wa; logic [1:0] ba; logic [7:0] aa; logic [15:0] wda;
    logic        eb; logic wb; logic [1:0] bb; logic [7:0] ab; logic [15:0] wdb;
    logic        va; logic [15:0] da; logic vb; logic [15:0] db; logic col;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    int n;
    logic bad;
    logic ea, wa, eb, wb;
    logic [1:0] ba, bb;
    logic [7:0] aa, ab;
    logic [15:0] wda, wdb;

    // fields: A{en,we,be,addr,data} B{en,we,be,addr,data} exp{va,da,vb,db,col}
    vecs[0]  = '{1'b1,1'b0,2'b00,8'd0,  16'h0000, 1'b1,1'b0,2'b00,8'd128,16'h0000, 1'b1,16'h0000,1'b1,16'h0000,1'b0};
    vecs[1]  = '{1'b1,1'b0,2'b00,8'd255,16'h0000, 1'b1,1'b0,2'b00,8'd3,  16'h0000, 1'b1,16'h0000,1'b1,16'h0000,1'b0};
    vecs[2]  = '{1'b1,1'b1,2'b11,8'd2,  16'd20,   1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'h0000,1'b0,16'h0000,1'b0};
    vecs[3]  = '{1'b1,1'b1,2'b11,8'd4,  16'd40,   1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'h0000,1'b0,16'h0000,1'b0};
    vecs[4]  = '{1'b1,1'b1,2'b11,8'd6,  16'd60,   1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'h0000,1'b0,16'h0000,1'b0};
    vecs[5]  = '{1'b1,1'b1,2'b11,8'd5,  16'h0005, 1'b1,1'b0,2'b00,8'd2,  16'h0000, 1'b0,16'h0000,1'b1,16'h0014,1'b0};
    vecs[6]  = '{1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b1,1'b0,2'b00,8'd4,  16'h0000, 1'b0,16'h0000,1'b1,16'h0028,1'b0};
    vecs[7]  = '{1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b1,1'b0,2'b00,8'd6,  16'h0000, 1'b0,16'h0000,1'b1,16'h003C,1'b0};
    vecs[8]  = '{1'b1,1'b1,2'b11,8'd9,  16'hAABB, 1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'h0000,1'b0,16'h003C,1'b0};
    vecs[9]  = '{1'b1,1'b1,2'b01,8'd9,  16'h1234, 1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'h0000,1'b0,16'h003C,1'b0};
    vecs[10] = '{1'b1,1'b0,2'b00,8'd9,  16'h0000, 1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b1,16'hAA34,1'b0,16'h003C,1'b0};
    vecs[11] = '{1'b1,1'b1,2'b01,8'd8,  16'h1111, 1'b1,1'b1,2'b11,8'd8,  16'h2222, 1'b0,16'hAA34,1'b0,16'h003C,1'b1};
    vecs[12] = '{1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b0,16'hAA34,1'b0,16'h003C,1'b0};
    vecs[13] = '{1'b1,1'b0,2'b00,8'd8,  16'h0000, 1'b0,1'b0,2'b00,8'd0,  16'h0000, 1'b1,16'h2211,1'b0,16'h003C,1'b0};
    vecs[14] = '{1'b1,1'b1,2'b11,8'd5,  16'h00FF, 1'b1,1'b0,2'b00,8'd5,  16'h0000, 1'b0,16'h2211,1'b1,RW_EXP,  1'b0};
    vecs[15] = '{1'b1,1'b0,2'b00,8'd6,  16'h0000, 1'b1,1'b0,2'b00,8'd5,  16'h0000, 1'b1,16'h003C,1'b1,16'h00FF,1'b0};
    vecs[16] = '{1'b1,1'b1,2'b00,8'd6,  16'hFFFF, 1'b1,1'b1,2'b10,8'd7,  16'h9999, 1'b0,16'h003C,1'b0,16'h00FF,1'b0};
    vecs[17] = '{1'b1,1'b0,2'b00,8'd6,  16'h0000, 1'b1,1'b0,2'b00,8'd7,  16'h0000, 1'b1,16'h003C,1'b1,16'h9900,1'b0};
    vecs[18] = '{1'b1,1'b1,2'b01,8'd1,  16'hABCD, 1'b1,1'b1,2'b01,8'd1,  16'h5678, 1'b0,16'h003C,1'b0,16'h9900,1'b1};
    vecs[19] = '{1'b1,1'b0,2'b00,8'd2,  16'h0000, 1'b1,1'b0,2'b00,8'd1,  16'h0000, 1'b1,16'h0014,1'b1,16'h00CD,1'b0};

    rst = 1'b1; rst2 = 1'b1;
    idle1();
    en_a2 = 1'b0; we_a2 = 1'b0; be_a2 = 2'b00; addr_a2 = 8'd0; data_a2 = 16'h0000;
    en_b2 = 1'b0; we_b2 = 1'b0; be_b2 = 2'b00; addr_b2 = 8'd0; data_b2 = 16'h0000;
    model_clear();
    #2;
    rst = 1'b0; rst2 = 1'b0;

    // ---- reset values ----
    @(posedge clk); @(posedge clk); #1;
    chk("rst dataout_a", 32'(dataout_a), 32'h0);
    chk("rst dataout_b", 32'(dataout_b), 32'h0);
    chk("rst valid_a", 32'(valid_a), 32'h0);
    chk("rst valid_b", 32'(valid_b), 32'h0);
    chk("rst collision", 32'(collision), 32'h0);
    chk("rst init_busy", 32'(init_busy), 32'h1);

    // ---- init sweep: requests must be dropped ----
    rst = 1'b1;
    n = 0;
    bad = 1'b0;
    while (init_busy && n < 1000) begin
      en_a = 1'b1; be_a = 2'b11; addr_a = 8'd3; data_a = 16'hFFFF;
      en_b = 1'b1; be_b = 2'b11; addr_b = 8'd3; data_b = 16'hFFFF;
      we_a = (n % 2 == 0); we_b = (n % 2 == 0);
      @(posedge clk);
      #1;
      n++;
      if (valid_a || valid_b || collision) bad = 1'b1;
    end
    idle1();
    chk("init_len", 32'(n), 32'd256);
    chk("init requests dropped", 32'(bad), 32'h0);

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].ea, vecs[i].wa, vecs[i].ba, vecs[i].aa, vecs[i].wda,
            vecs[i].eb, vecs[i].wb, vecs[i].bb, vecs[i].ab, vecs[i].wdb);
      chk($sformatf("vec%0d valid_a", i), 32'(valid_a), 32'(vecs[i].va));
      chk($sformatf("vec%0d dataout_a", i), 32'(dataout_a), 32'(vecs[i].da));
      chk($sformatf("vec%0d valid_b", i), 32'(valid_b), 32'(vecs[i].vb));
      chk($sformatf("vec%0d dataout_b", i), 32'(dataout_b), 32'(vecs[i].db));
      chk($sformatf("vec%0d collision", i), 32'(collision), 32'(vecs[i].col));
    end

    // ---- randomized back-to-back traffic against the model ----
    for (int i = 0; i < 300; i++) begin
      ea = 1'($urandom_range(0, 1)); wa = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      ba = 2'($urandom_range(0, 3)); bb = 2'($urandom_range(0, 3));
      aa = 8'($urandom_range(0, 15)); ab = 8'($urandom_range(0, 15));
      wda = 16'($urandom); wdb = 16'($urandom);
      apply(ea, wa, ba, aa, wda, eb, wb, bb, ab, wdb);
      check_model($sformatf("rnd%0d", i));
    end

    // ---- reset in RUN: outputs clear immediately, pending write lost ----
    apply(1'b1, 1'b1, 2'b11, 8'd100, 16'h5A5A, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0000);
    apply(1'b1, 1'b0, 2'b00, 8'd100, 16'h0000, 1'b1, 1'b0, 2'b00, 8'd100, 16'h0000);
    check_model("pre-reset");
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 8'd100; data_a = 16'h7777;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("runrst dataout_a", 32'(dataout_a), 32'h0);
    chk("runrst dataout_b", 32'(dataout_b), 32'h0);
    chk("runrst valid_a", 32'(valid_a), 32'h0);
    chk("runrst init_busy", 32'(init_busy), 32'h1);
    idle1();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // ---- reset again mid-sweep at count 100 ----
    repeat (100) @(posedge clk);
    #1;
    chk("midsweep init_busy", 32'(init_busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("midsweep dataout_a", 32'(dataout_a), 32'h0);
    chk("midsweep valid_b", 32'(valid_b), 32'h0);
    chk("midsweep init_busy held", 32'(init_busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    count_init1(n);
    chk("reinit_len", 32'(n), 32'd256);
    model_clear();
    apply(1'b1, 1'b0, 2'b00, 8'd100, 16'h0000, 1'b1, 1'b0, 2'b00, 8'd9, 16'h0000);
    check_model("post-reinit");

    // ---- DEPTH=200 instance: sweep length and out-of-range handling ----
    rst2 = 1'b1;
    n = 0;
    while (init_busy2 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("d200 init_len", 32'(n), 32'd200);
    en_a2 = 1'b1; we_a2 = 1'b1; be_a2 = 2'b11; addr_a2 = 8'd250; data_a2 = 16'hBEEF;
    en_b2 = 1'b1; we_b2 = 1'b0; be_b2 = 2'b00; addr_b2 = 8'd199; data_b2 = 16'h0000;
    @(posedge clk); #1;
    chk("d200 rd199 valid", 32'(valid_b2), 32'h1);
    chk("d200 rd199 data", 32'(dataout_b2), 32'h0);
    chk("d200 oor write valid_a", 32'(valid_a2), 32'h0);
    en_a2 = 1'b1; we_a2 = 1'b0; addr_a2 = 8'd250;
    en_b2 = 1'b1; we_b2 = 1'b1; be_b2 = 2'b11; addr_b2 = 8'd199; data_b2 = 16'h1234;
    @(posedge clk); #1;
    chk("d200 rd250 valid", 32'(valid_a2), 32'h1);
    chk("d200 rd250 data", 32'(dataout_a2), 32'h0);
    en_a2 = 1'b0; we_a2 = 1'b0;
    en_b2 = 1'b1; we_b2 = 1'b0; addr_b2 = 8'd199;
    @(posedge clk); #1;
    chk("d200 rd199 new data", 32'(dataout_b2), 32'h1234);
    en_b2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
